// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped one-word-per-frame instruction cache with single-miss fill FSM
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
module icache #(
    parameter int SETS = 16
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hitcount,
    output logic [31:0] misscount
`endif
);

    localparam int IW = $clog2(SETS);
    localparam int TW = 30 - IW;

    typedef enum logic {
        IDLE,
        FILL
    } state_e;

    state_e          state_q;
    logic [29:0]     fill_addr_q;
    logic            valid_q [SETS];
    logic [TW-1:0]   tag_q   [SETS];
    logic [31:0]     data_q  [SETS];

    logic [IW-1:0]   req_idx;
    logic [TW-1:0]   req_tag;
    logic [IW-1:0]   fill_idx;
    logic [TW-1:0]   fill_tag;
    logic            lookup_hit;
    logic            miss;
    logic            unused_byte_offset;

    assign req_idx  = imemaddr[IW+1:2];
    assign req_tag  = imemaddr[31:IW+2];
    assign fill_idx = fill_addr_q[IW-1:0];
    assign fill_tag = fill_addr_q[29:IW];

    // Byte offset never selects anything: frames hold exactly one word.
    assign unused_byte_offset = ^imemaddr[1:0];

    // Lookup depends only on request inputs and stored flops, never on iload/iwait.
    assign lookup_hit = imemREN && valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign ihit       = (state_q == IDLE) && lookup_hit;
    assign miss       = (state_q == IDLE) && imemREN && !lookup_hit;
    assign imemload   = ihit ? data_q[req_idx] : 32'h0;

    assign iREN  = (state_q == FILL);
    assign iaddr = iREN ? {fill_addr_q, 2'b00} : 32'h0;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= IDLE;
            fill_addr_q <= '0;
            for (int i = 0; i < SETS; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                data_q[i]  <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (miss) begin
                        fill_addr_q <= imemaddr[31:2];
                        state_q     <= FILL;
                    end
                end
                FILL: begin
                    // The latched address owns the fill; request changes wait for IDLE.
                    if (!iwait) begin
                        valid_q[fill_idx] <= 1'b1;
                        tag_q[fill_idx]   <= fill_tag;
                        data_q[fill_idx]  <= iload;
                        state_q           <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            hit_cnt_q  <= 32'h0;
            miss_cnt_q <= 32'h0;
        end else begin
            if (ihit) begin
                hit_cnt_q <= hit_cnt_q + 32'h1;
            end
            if (miss) begin
                miss_cnt_q <= miss_cnt_q + 32'h1;
            end
        end
    end

    assign hitcount  = hit_cnt_q;
    assign misscount = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache.sv
// tb/tb_icache.sv - scoreboard bench for icache: directed misses, fills, conflicts and resets
module tb_icache;

    logic        CLK;
    logic        nRST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
`ifdef ICACHE_STATS_EN
    logic [31:0] hitcount;
    logic [31:0] misscount;
`endif

    int compared   = 0;
    int mismatched = 0;
    logic [31:0] exp_q[$];

    icache #(.SETS(16)) dut (
        .CLK(CLK),
        .nRST(nRST),
        .imemREN(imemREN),
        .imemaddr(imemaddr),
        .ihit(ihit),
        .imemload(imemload),
        .iREN(iREN),
        .iaddr(iaddr),
        .iwait(iwait),
        .iload(iload)
`ifdef ICACHE_STATS_EN
        ,
        .hitcount(hitcount),
        .misscount(misscount)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: actual=%h expected=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Data monitor: every hit must match the next queued word; no hit means a zero bus.
    always @(negedge CLK) begin
        if (nRST) begin
            if (ihit === 1'b1) begin
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_hit: imemload=%h addr=%h", imemload, imemaddr);
                end else begin
                    chk("hit_data", imemload, exp_q.pop_front());
                end
            end else begin
                chk("miss_data_zero", imemload, 32'h0);
            end
        end
    end

    // Check control outputs in the current cycle, then advance to just after the next edge.
    task automatic cycle(input logic eh, input logic er, input logic [31:0] ea, input string nm);
        @(negedge CLK);
        chk({nm, "_ihit"}, {31'h0, ihit}, {31'h0, eh});
        chk({nm, "_iREN"}, {31'h0, iREN}, {31'h0, er});
        chk({nm, "_iaddr"}, iaddr, ea);
        @(posedge CLK);
        #1;
    endtask

    task automatic fill(input logic [31:0] addr, input logic [31:0] data, input int nwait);
        imemREN  = 1'b1;
        imemaddr = addr;
        iwait    = 1'b1;
        cycle(1'b0, 1'b0, 32'h0, "miss");
        for (int i = 0; i < nwait; i++) begin
            cycle(1'b0, 1'b1, addr & 32'hFFFF_FFFC, "fill_wait");
        end
        iwait = 1'b0;
        iload = data;
        cycle(1'b0, 1'b1, addr & 32'hFFFF_FFFC, "fill_done");
        iwait = 1'b1;
        iload = 32'hBAD0_BAD0;
        exp_q.push_back(data);
        cycle(1'b1, 1'b0, 32'h0, "hit_after_fill");
    endtask

    task automatic hit(input logic [31:0] addr, input logic [31:0] data);
        imemREN  = 1'b1;
        imemaddr = addr;
        exp_q.push_back(data);
        cycle(1'b1, 1'b0, 32'h0, "hit");
    endtask

    task automatic do_reset();
        imemREN = 1'b0;
        nRST    = 1'b0;
        @(negedge CLK);
        #2;
        nRST = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        nRST     = 1'b0;
        imemREN  = 1'b0;
        imemaddr = 32'h40;
        iwait    = 1'b1;
        iload    = 32'h0;
        #3;
        chk("rst_ihit", {31'h0, ihit}, 32'h0);
        chk("rst_imemload", imemload, 32'h0);
        chk("rst_iREN", {31'h0, iREN}, 32'h0);
        chk("rst_iaddr", iaddr, 32'h0);
        do_reset();

        fill(32'h40, 32'h8C22_0004, 2);
        hit(32'h40, 32'h8C22_0004);

        // Conflict in set 0: 0x440 evicts 0x40, then 0x40 misses again.
        fill(32'h440, 32'h1111_1111, 1);
        hit(32'h440, 32'h1111_1111);
        fill(32'h40, 32'h2222_2222, 0);

        // Highest set index.
        fill(32'h3C, 32'h3C3C_3C3C, 1);
        hit(32'h3C, 32'h3C3C_3C3C);

        // Request switched away during a fill; the latched address completes.
        fill(32'h80, 32'h3333_3333, 0);
        imemaddr = 32'h40;
        cycle(1'b0, 1'b0, 32'h0, "sw_miss");
        imemaddr = 32'h80;
        cycle(1'b0, 1'b1, 32'h40, "sw_fill_a");
        imemREN = 1'b0;
        cycle(1'b0, 1'b1, 32'h40, "sw_fill_b");
        imemREN = 1'b1;
        iwait   = 1'b0;
        iload   = 32'h4444_4444;
        cycle(1'b0, 1'b1, 32'h40, "sw_fill_done");
        iwait = 1'b1;
        hit(32'h40, 32'h4444_4444);
        fill(32'h80, 32'h5555_5555, 0);

        // No request: nothing happens whatever the address is.
        imemREN = 1'b0;
        for (int i = 0; i < 10; i++) begin
            imemaddr = (i % 3 == 0) ? 32'h80 : $urandom;
            cycle(1'b0, 1'b0, 32'h0, "idle");
        end

        // Reset in the middle of a fill aborts it without writing the frame.
        fill(32'h47, 32'h6666_6666, 0);
        imemREN  = 1'b1;
        imemaddr = 32'h48;
        cycle(1'b0, 1'b0, 32'h0, "rf_miss");
        @(negedge CLK);
        chk("rf_in_fill_iREN", {31'h0, iREN}, 32'h1);
        #1;
        nRST  = 1'b0;
        iwait = 1'b0;
        iload = 32'hDEAD_BEEF;
        #1;
        chk("rf_async_iREN", {31'h0, iREN}, 32'h0);
        chk("rf_async_iaddr", iaddr, 32'h0);
        chk("rf_async_ihit", {31'h0, ihit}, 32'h0);
        @(posedge CLK);
        #1;
        iwait = 1'b1;
        do_reset();
        fill(32'h48, 32'h7777_7777, 0);
        fill(32'h44, 32'h8888_8888, 1);

`ifdef ICACHE_STATS_EN
        do_reset();
        chk("stats_rst_hit", hitcount, 32'h0);
        chk("stats_rst_miss", misscount, 32'h0);
        fill(32'h40, 32'hABCD_0001, 1);
        hit(32'h40, 32'hABCD_0001);
        hit(32'h40, 32'hABCD_0001);
        hit(32'h40, 32'hABCD_0001);
        imemREN = 1'b0;
        @(negedge CLK);
        chk("stats_hitcount", hitcount, 32'd4);
        chk("stats_misscount", misscount, 32'd1);
`endif

        imemREN = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("scoreboard_drained", exp_q.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
